rr_mux_sched: RTL and testbench

- Round-robin scheduler sharing one p_nbits-wide output channel among p_nreqs val/rdy requesters.
- Arbitrates each cycle, steers the granted message through an internal N:1 select, and captures it in a one-entry output register.
- Sits in front of shared resources such as a memory port or a writeback bus, where several producers contend for one consumer.
- Registered output; full throughput of 1 message/cycle when out_rdy stays high.

---
 rtl/rr_mux_sched_pkg.sv | 12 +
 rtl/rr_mux_sched_arb.sv | 34 +++
 rtl/rr_mux_sched.sv | 105 ++++++++++
 tb/tb_rr_mux_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler.
// The optional packet-lock feature is enabled with RR_MUX_SCHED_LOCK_EN.
package rr_mux_sched_pkg;

  typedef enum logic {EMPTY, FULL} state_t;

  // Pointer/source index width; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_sched_arb.sv
// Combinational rotating-priority picker: first asserted valid at or
// after ptr, wrapping modulo p_nreqs.
module rr_mux_sched_arb
  import rr_mux_sched_pkg::*;
#(
  parameter int p_nreqs = 4,
  localparam int c_sbits = ptr_width(p_nreqs)
) (
  input  logic [p_nreqs-1:0]  in_val,
  input  logic [c_sbits-1:0]  ptr,
  output logic [c_sbits-1:0]  grant,
  output logic                gnt_val
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < p_nreqs; k++) begin
      idx = int'(ptr) + k;
      if (idx >= p_nreqs) idx = idx - p_nreqs;
      if (!found && in_val[c_sbits'(idx)]) begin
        found = 1'b1;
        grant = c_sbits'(idx);
      end
    end
  end

  assign gnt_val = |in_val;

endmodule

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler muxing p_nreqs val/rdy requesters into one
// registered output channel. Define RR_MUX_SCHED_LOCK_EN for packet lock.
module rr_mux_sched
  import rr_mux_sched_pkg::*;
#(
  parameter int p_nbits = 32,
  parameter int p_nreqs = 4,
  localparam int c_sbits = ptr_width(p_nreqs)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [p_nreqs-1:0]          in_val,
  output logic [p_nreqs-1:0]          in_rdy,
  input  logic [p_nreqs*p_nbits-1:0]  in_msg,
`ifdef RR_MUX_SCHED_LOCK_EN
  input  logic [p_nreqs-1:0]          in_last,
`endif
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [p_nbits-1:0]          out_msg,
  output logic [c_sbits-1:0]          out_src
);

  state_t               state;
  logic [c_sbits-1:0]   ptr;
  logic [c_sbits-1:0]   arb_ptr;
  logic [c_sbits-1:0]   grant;
  logic [c_sbits-1:0]   next_ptr;
  logic [p_nreqs-1:0]   arb_val;
  logic                 gnt_val;
  logic                 can_accept;
  logic                 xfer;

`ifdef RR_MUX_SCHED_LOCK_EN
  logic                 lock;
  logic [c_sbits-1:0]   lock_id;
  logic                 grant_last;

  // While locked, only the owning requester is visible to the picker.
  always_comb begin
    arb_val = in_val;
    arb_ptr = ptr;
    if (lock) begin
      arb_val = in_val & (p_nreqs'(1) << lock_id);
      arb_ptr = lock_id;
    end
  end

  assign grant_last = in_last[grant];
`else
  assign arb_val = in_val;
  assign arb_ptr = ptr;
`endif

  rr_mux_sched_arb #(.p_nreqs(p_nreqs)) arb (
    .in_val  (arb_val),
    .ptr     (arb_ptr),
    .grant   (grant),
    .gnt_val (gnt_val)
  );

  assign can_accept = (state == EMPTY) | out_rdy;
  assign xfer       = reset & can_accept & gnt_val;
  assign out_val    = (state == FULL);
  assign next_ptr   = (grant == c_sbits'(p_nreqs - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    in_rdy = '0;
    if (xfer) in_rdy[grant] = 1'b1;
  end

  // Dequeue and enqueue can coincide, in which case the register stays FULL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= EMPTY;
      out_msg <= '0;
      out_src <= '0;
      ptr     <= '0;
`ifdef RR_MUX_SCHED_LOCK_EN
      lock    <= 1'b0;
      lock_id <= '0;
`endif
    end else begin
      if (xfer) begin
        state   <= FULL;
        out_msg <= in_msg[int'(grant)*p_nbits +: p_nbits];
        out_src <= grant;
`ifdef RR_MUX_SCHED_LOCK_EN
        if (grant_last) begin
          lock <= 1'b0;
          ptr  <= next_ptr;
        end else begin
          lock    <= 1'b1;
          lock_id <= grant;
        end
`else
        ptr <= next_ptr;
`endif
      end else if (out_rdy) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_sched.sv
// Randomized and directed bench for rr_mux_sched against a queue-free
// behavioural model of round-robin arbitration into a one-entry buffer.
module tb_rr_mux_sched;

  localparam int NB = 32;
  localparam int NR = 4;
  localparam int SB = 2;

  logic               clk;
  logic               reset;
  logic [NR-1:0]      in_val;
  logic [NR-1:0]      in_rdy;
  logic [NR*NB-1:0]   in_msg;
  logic               out_val;
  logic               out_rdy;
  logic [NB-1:0]      out_msg;
  logic [SB-1:0]      out_src;
`ifdef RR_MUX_SCHED_LOCK_EN
  logic [NR-1:0]      in_last;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_full = 0;
  int          m_ptr  = 0;
  int          m_src  = 0;
  logic [NB-1:0] m_msg = '0;

  rr_mux_sched #(.p_nbits(NB), .p_nreqs(NR)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
`ifdef RR_MUX_SCHED_LOCK_EN
    .in_last (in_last),
`endif
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input int i, input logic [NB-1:0] v);
    in_msg[i*NB +: NB] = v;
  endtask

  // One cycle: drive inputs, check in_rdy before the edge, step the model,
  // check registered outputs after the edge.
  task automatic applyStimulus(input bit rst_n, input logic [NR-1:0] val, input bit rdy);
    int g;
    int idx;
    bit can_acc;
    bit xfer;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    reset   = rst_n;
    in_val  = val;
    out_rdy = rdy;
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (g < 0 && val[idx]) g = idx;
    end
    can_acc = !m_full || rdy;
    xfer    = rst_n && can_acc && (g >= 0);
    exp_rdy = xfer ? NR'(1 << g) : '0;
    checkOutput("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_full = 0;
      m_ptr  = 0;
      m_src  = 0;
      m_msg  = '0;
    end else if (xfer) begin
      m_full = 1;
      m_msg  = in_msg[g*NB +: NB];
      m_src  = g;
      m_ptr  = (g + 1) % NR;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    #1;
    checkOutput("out_val", 64'(out_val), 64'(m_full));
    if (m_full) begin
      checkOutput("out_msg", 64'(out_msg), 64'(m_msg));
      checkOutput("out_src", 64'(out_src), 64'(m_src));
    end
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = '0;
    out_rdy = 1'b0;
    in_msg  = '0;
`ifdef RR_MUX_SCHED_LOCK_EN
    in_last = '1;
`endif

    // Reset, then idle
    applyStimulus(0, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 0);
    checkOutput("rst_out_msg", 64'(out_msg), 64'h0);
    checkOutput("rst_out_src", 64'(out_src), 64'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'b0000, 1);
      checkOutput("idle_val", 64'(out_val), 64'h0);
    end

    // All requesters valid: rotating sources 0,1,2,3,0
    for (int i = 0; i < NR; i++) set_msg(i, NB'(32'hA0 + i));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'b1111, 1);
      checkOutput("rr_src", 64'(out_src), 64'(i % NR));
      checkOutput("rr_msg", 64'(out_msg), 64'(32'hA0 + (i % NR)));
    end
    applyStimulus(1, 4'b0000, 1);

    // Requester 2 accepted, then back-pressure for 3 cycles
    set_msg(2, 32'h0000_C0C2);
    applyStimulus(1, 4'b0100, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b0100, 0);
      checkOutput("stall_msg", 64'(out_msg), 64'h0000_C0C2);
      checkOutput("stall_rdy", 64'(in_rdy), 64'h0);
    end
    // Simultaneous dequeue and enqueue
    set_msg(0, 32'h0000_B0B0);
    applyStimulus(1, 4'b0001, 1);
    checkOutput("deq_enq_val", 64'(out_val), 64'h1);
    checkOutput("deq_enq_src", 64'(out_src), 64'h0);
    applyStimulus(1, 4'b0000, 1);

    // Drive ptr to 3, then 0101 wraps to 0, then 2
    applyStimulus(1, 4'b0100, 1);
    applyStimulus(1, 4'b0101, 1);
    checkOutput("wrap_src0", 64'(out_src), 64'h0);
    applyStimulus(1, 4'b0101, 1);
    checkOutput("wrap_src2", 64'(out_src), 64'h2);
    applyStimulus(1, 4'b0000, 1);

    // Reset while FULL drops the buffered message
    set_msg(1, 32'h0000_DEAD);
    applyStimulus(1, 4'b0010, 0);
    checkOutput("dead_msg", 64'(out_msg), 64'h0000_DEAD);
    applyStimulus(0, 4'b0010, 1);
    checkOutput("mid_rst_val", 64'(out_val), 64'h0);
    applyStimulus(1, 4'b1111, 1);
    checkOutput("post_rst_src", 64'(out_src), 64'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NR; r++) set_msg(r, NB'($urandom));
      applyStimulus(($urandom_range(0, 49) != 0), NR'($urandom), bit'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
